// File: rtl/lane_serializer.sv
// Snapshots SIZE lanes of {a,b,c} bits on a load request and streams them
// out one lane per beat over a valid/ready handshake, with snapshot popcount.
module lane_serializer #(
    parameter  int SIZE = 8,
    localparam int LW   = $clog2(SIZE),
    localparam int CW   = $clog2(3*SIZE+1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    input  logic [SIZE-1:0] i_c,
    input  logic            i_load,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [2:0]      o_data,
    output logic [LW-1:0]   o_lane,
    output logic            o_last,
    output logic [CW-1:0]   o_ones,
    output logic            o_busy,
    output logic            o_drop,
    output logic            o_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] snap_a_q, snap_a_d;
    logic [SIZE-1:0] snap_b_q, snap_b_d;
    logic [SIZE-1:0] snap_c_q, snap_c_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic            drop_q, drop_d;
    logic            done_q, done_d;
    logic            capture_s;
    logic            last_s;

    function automatic logic [CW-1:0] popcount(input logic [3*SIZE-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < 3*SIZE; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    assign last_s = (lane_q == LW'(SIZE-1));

    // Next-state: handshake sequencing, drop/done pulses and snapshot capture
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        drop_d    = 1'b0;
        done_d    = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load) begin
                    capture_s = 1'b1;
                    lane_d    = {LW{1'b0}};
                    state_d   = SEND;
                end else begin
                    state_d   = IDLE;
                end
            end
            SEND: begin
                if (i_ready && last_s) begin
                    // a load on the final transfer reloads with no bubble
                    done_d = 1'b1;
                    lane_d = {LW{1'b0}};
                    if (i_load) begin
                        capture_s = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d   = IDLE;
                    end
                end else if (i_ready) begin
                    lane_d = lane_q + LW'(1'b1);
                    drop_d = i_load;
                end else begin
                    drop_d = i_load;
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = {LW{1'b0}};
            end
        endcase
        if (capture_s) begin
            snap_a_d = i_a;
            snap_b_d = i_b;
            snap_c_d = i_c;
            ones_d   = popcount({i_a, i_b, i_c});
        end else begin
            snap_a_d = snap_a_q;
            snap_b_d = snap_b_q;
            snap_c_d = snap_c_q;
            ones_d   = ones_q;
        end
    end

    // State and snapshot registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            snap_a_q <= {SIZE{1'b0}};
            snap_b_q <= {SIZE{1'b0}};
            snap_c_q <= {SIZE{1'b0}};
            lane_q   <= {LW{1'b0}};
            ones_q   <= {CW{1'b0}};
            drop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
            snap_c_q <= snap_c_d;
            lane_q   <= lane_d;
            ones_q   <= ones_d;
            drop_q   <= drop_d;
            done_q   <= done_d;
        end
    end

    assign o_valid = (state_q == SEND);
    assign o_busy  = (state_q == SEND);
    assign o_data  = o_valid ? {snap_a_q[lane_q], snap_b_q[lane_q], snap_c_q[lane_q]} : 3'b000;
    assign o_lane  = o_valid ? lane_q : {LW{1'b0}};
    assign o_last  = o_valid && last_s;
    assign o_ones  = ones_q;
    assign o_drop  = drop_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Directed, table-driven bench for lane_serializer at SIZE=8.
module tb_lane_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b, c;
    logic       load, ready;
    logic       o_valid, o_last, o_busy, o_drop, o_done;
    logic [2:0] o_data, o_lane;
    logic [4:0] o_ones;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lane_serializer #(.SIZE(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_a     (a),
        .i_b     (b),
        .i_c     (c),
        .i_load  (load),
        .i_ready (ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_lane  (o_lane),
        .o_last  (o_last),
        .o_ones  (o_ones),
        .o_busy  (o_busy),
        .o_drop  (o_drop),
        .o_done  (o_done)
    );

    wire [15:0] act = {o_valid, o_data, o_lane, o_last, o_ones, o_busy, o_drop, o_done};

    typedef struct {
        logic [7:0]  a, b, c;
        logic        load, ready;
        logic [15:0] exp;
    } vec_t;

    vec_t vec [10];

    function automatic logic [15:0] ep(input logic v, input logic [2:0] d, input logic [2:0] l,
                                       input logic la, input logic [4:0] on, input logic bu,
                                       input logic dr, input logic dn);
        return {v, d, l, la, on, bu, dr, dn};
    endfunction

    // Expected beat for a snapshot and lane
    function automatic logic [2:0] sd(input logic [7:0] sa, input logic [7:0] sb,
                                      input logic [7:0] sc, input int l);
        return {sa[l], sb[l], sc[l]};
    endfunction

    function automatic logic [2:0] d2(input int l);
        return (l == 0) ? 3'b100 : ((l == 7) ? 3'b010 : 3'b000);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {v,d,l,last,ones,busy,drop,done}=%b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        int xf;
        logic [15:0] zero16;
        zero16 = 16'h0000;

        vec[0] = '{8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, ep(1'b1, 3'b101, 3'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0)};
        for (int i = 1; i < 8; i++)
            vec[i] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1,
                       ep(1'b1, 3'b101, 3'(i), (i == 7), 5'd16, 1'b1, 1'b0, 1'b0)};
        vec[8] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, ep(1'b0, 3'b000, 3'd0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b1)};
        vec[9] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, ep(1'b0, 3'b000, 3'd0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0)};

        rst_n = 1'b0;
        a = 8'h00; b = 8'h00; c = 8'h00; load = 1'b0; ready = 1'b0;
        #2;
        chk("reset", zero16);
        #10;
        rst_n = 1'b1;

        // Full stream with ready held high
        for (int i = 0; i < 10; i++) begin
            a = vec[i].a; b = vec[i].b; c = vec[i].c;
            load = vec[i].load; ready = vec[i].ready;
            step();
            chk($sformatf("tbl%0d", i), vec[i].exp);
        end

        // Idle with ready high: nothing happens, ones holds
        a = 8'h00; b = 8'h00; c = 8'h00; load = 1'b0; ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("idle%0d", k), ep(1'b0, 3'b000, 3'd0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0));
        end

        // Stalls with ready pattern 1,0,0,1
        a = 8'h01; b = 8'h80; c = 8'h00; load = 1'b1; ready = 1'b0;
        step();
        chk("stall_load", ep(1'b1, 3'b100, 3'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0));
        load = 1'b0;
        a = 8'hFF; b = 8'hFF; c = 8'hFF;
        xf = 0;
        for (int k = 0; k < 40 && xf < 8; k++) begin
            ready = ((k % 4) == 0 || (k % 4) == 3);
            step();
            if (ready) xf++;
            if (xf == 8)
                chk("stall_end", ep(1'b0, 3'b000, 3'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1));
            else
                chk($sformatf("stall_k%0d", k), ep(1'b1, d2(xf), 3'(xf), (xf == 7), 5'd2, 1'b1, 1'b0, 1'b0));
        end
        n_vec++;
        if (xf != 8) begin
            n_err++;
            $display("FAIL stall_xfers: got %0d transfers expected 8", xf);
        end
        ready = 1'b1;
        step();
        chk("stall_idle", ep(1'b0, 3'b000, 3'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0));

        // Load while busy at lane 3 is dropped
        a = 8'h0F; b = 8'hF0; c = 8'h01; load = 1'b1; ready = 1'b1;
        step();
        chk("drop_l0", ep(1'b1, sd(8'h0F, 8'hF0, 8'h01, 0), 3'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0));
        load = 1'b0;
        for (int l = 1; l < 4; l++) begin
            step();
            chk($sformatf("drop_l%0d", l), ep(1'b1, sd(8'h0F, 8'hF0, 8'h01, l), 3'(l), 1'b0, 5'd9, 1'b1, 1'b0, 1'b0));
        end
        a = 8'hFF; b = 8'hFF; c = 8'hFF; load = 1'b1; ready = 1'b0;
        step();
        chk("drop_pulse", ep(1'b1, sd(8'h0F, 8'hF0, 8'h01, 3), 3'd3, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0));
        load = 1'b0; ready = 1'b1;
        for (int l = 4; l < 8; l++) begin
            step();
            chk($sformatf("drop_after_l%0d", l), ep(1'b1, sd(8'h0F, 8'hF0, 8'h01, l), 3'(l), (l == 7), 5'd9, 1'b1, 1'b0, 1'b0));
        end

        // Zero-bubble reload on the lane-7 transfer
        a = 8'hAA; b = 8'hAA; c = 8'hAA; load = 1'b1; ready = 1'b1;
        step();
        chk("reload_l0", ep(1'b1, 3'b000, 3'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1));
        load = 1'b0;
        for (int l = 1; l < 6; l++) begin
            step();
            chk($sformatf("reload_l%0d", l), ep(1'b1, (l % 2 == 1) ? 3'b111 : 3'b000, 3'(l), 1'b0, 5'd12, 1'b1, 1'b0, 1'b0));
        end

        // Asynchronous reset mid-cycle at lane 5
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", zero16);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("post_rst%0d", k), zero16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Downstream consumer of the SIZE-lane signal array (per-lane bits x/y/z, flattened to vectors i_a/i_b/i_c) produced by the lane-driving stage.
- On a load request, snapshots all SIZE lanes and streams them out one lane per beat over a valid/ready handshake.
- Reports a ones-count of the snapshot and flags load requests it cannot accept.
- Sits between the lane array and a narrow serial/debug sink.

Parameters:
- SIZE, 8, number of lanes; legal range 2..256.
- LW, $clog2(SIZE), lane-index width (derived; not overridden).
- CW, $clog2(3*SIZE+1), ones-count width (derived; not overridden).

Ports:
- i_clk  input  1  sole clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_a  input  SIZE  lane x bits; bit i = lane i.
- i_b  input  SIZE  lane y bits.
- i_c  input  SIZE  lane z bits.
- i_load  input  1  request to snapshot i_a/i_b/i_c.
- i_ready  input  1  sink accepts the current beat.
- o_valid  output  1  beat present on o_data/o_lane.
- o_data  output  3  {a,b,c} of the current lane; bit 2 = a.
- o_lane  output  LW  index of the current lane.
- o_last  output  1  current beat is lane SIZE-1.
- o_ones  output  CW  count of 1 bits across the snapshot (3*SIZE bits).
- o_busy  output  1  serializer holds an unsent snapshot.
- o_drop  output  1  one-cycle pulse: i_load was ignored.
- o_done  output  1  one-cycle pulse after the last beat transfers.

Behaviour:
- Interface: one clock (i_clk); reset i_rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0, including o_data, o_lane, o_ones, o_valid, o_busy, o_drop and o_done.
- Transfer: a beat transfers on a rising edge where o_valid && i_ready.
- States:
  - IDLE: o_valid=0, o_busy=0. If i_load=1, capture i_a/i_b/i_c into the snapshot register, set lane=0 and go to SEND. o_ones updates to the snapshot popcount on the same edge.
  - SEND: o_valid=1, o_busy=1.
    - o_data = {snap_a[lane], snap_b[lane], snap_c[lane]}; o_lane = lane; o_last = (lane==SIZE-1).
    - On a transfer with lane<SIZE-1: lane increments.
    - On a transfer with lane==SIZE-1: go to IDLE and pulse o_done the next cycle, unless the reload rule below applies.
- Latency: load on edge N -> o_valid=1 with lane 0 after edge N. Minimum SIZE cycles per snapshot when i_ready is held at 1.
- Stall: while o_valid && !i_ready, o_data/o_lane/o_last hold stable. The snapshot is immune to changes on i_a/i_b/i_c.
- Load while busy: i_load in SEND without a last-beat transfer that cycle is ignored. o_drop pulses high for 1 cycle after that edge, and the snapshot and o_ones are unchanged.
- Zero-bubble reload: i_load coincident with the last-beat transfer captures the new snapshot, stays in SEND with lane=0 and recaptures o_ones. In that case:
  - o_done still pulses.
  - o_drop stays 0.
  - o_valid stays 1 with no gap.
- o_ones holds its value until the next accepted load; it is not cleared in IDLE.
- i_ready in IDLE has no effect.
- Reset asserted mid-stream clears the state immediately (asynchronous). After release, no beat is replayed and o_done does not pulse.
- No combinational path from inputs to outputs; all outputs are registered or decoded from registered state.

Test Plan:
- SIZE=8; i_a=8'hFF, i_b=8'h00, i_c=8'hFF; 1-cycle i_load; i_ready=1 -> 8 consecutive beats, o_data=3'b101, o_lane 0..7, o_last on lane 7 only, o_ones=16, o_done 1 cycle after beat 7, then o_valid=0.
- i_a=8'h01, i_b=8'h80, i_c=8'h00; i_ready toggling 1,0,0,1,... -> o_data=3'b100 at lane 0, 3'b010 at lane 7, 3'b000 elsewhere. Each beat is held stable through stalls; exactly 8 transfers; o_ones=2.
- During SEND at lane 3, pulse i_load and change i_a/i_b/i_c -> o_drop high for 1 cycle; remaining beats still show the original snapshot; o_ones unchanged.
- Assert i_load in the same cycle as the lane-7 transfer with new inputs i_a=i_b=i_c=8'hAA -> o_valid stays 1; next beat is lane 0 with o_data=3'b000 (lane 0 bit of 8'hAA = 0); lane 1 has 3'b111; o_ones=12; o_done pulses; o_drop=0.
- Drop i_rst_n asynchronously (mid-cycle) at lane 5 -> all outputs 0 immediately. After release with i_load=0, o_valid stays 0 and o_done is never seen.
- i_ready=1 held in IDLE with no i_load for 20 cycles -> o_valid, o_done and o_drop stay 0; o_ones holds its last value.
